reg_bank_seq_ctrl: RTL

Per-instruction sequencer for the register bank encapsulation. It accepts one 32-bit ARM instruction per valid/ready handshake and holds it on the bank's IR input. It then drives LATCH_REG, PC_MUX, RD_MUX, DATA_MUX and REG_GATE_A/B/C through execute, optional multi-cycle multiply, and PC-increment phases. It sits between instruction fetch and the register bank/ALU datapath.

---
 rtl/reg_bank_ctrl_pkg.sv | 39 +++
 rtl/reg_bank_ir_decode.sv | 42 ++++
 rtl/reg_bank_seq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/reg_bank_ctrl_pkg.sv
// Shared definitions for the register bank sequencer.
// Holds the controller state encoding, ARM instruction field positions
// and the decode constants used by both the IR decoder and the sequencer top.
package reg_bank_ctrl_pkg;

    // Sequencer phases for one instruction
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_MUL    = 2'd2,
        ST_PC_INC = 2'd3
    } state_e;

    // Register fields of a 32-bit ARM instruction
    localparam int RN_HI  = 19;
    localparam int RN_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 12;
    localparam int RS_HI  = 11;
    localparam int RS_LO  = 8;
    localparam int RM_HI  = 3;
    localparam int RM_LO  = 0;
    localparam int OPC_HI = 24;
    localparam int OPC_LO = 21;

    // Immediate-operand flag and register-shift flag
    localparam int IMM_BIT   = 25;
    localparam int SHREG_BIT = 4;

    // IR[7:4] pattern that marks a multiply
    localparam logic [3:0] MUL_SIG = 4'b1001;

    // Index of the program counter in the register bank
    localparam logic [3:0] PC_IDX = 4'd15;

    // Top two opcode bits shared by TST/TEQ/CMP/CMN
    localparam logic [1:0] CMP_OPC_MASK = 2'b10;

endpackage

// File: rtl/reg_bank_ir_decode.sv
// Combinational instruction classifier for the register bank sequencer.
// Ports:
//   ir          - instruction to classify
//   is_mul      - supported multiply (Rd in IR[19:16] is not the PC)
//   is_dp       - data-processing instruction (not a multiply)
//   is_illegal  - anything the sequencer cannot execute
//   writes_rd   - instruction writes a destination register
//   rd_is_pc    - IR[15:12] selects the PC
//   use_c       - register-specified shift, so Rs is needed on C_BUS
module reg_bank_ir_decode
    import reg_bank_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_mul,
    output logic        is_dp,
    output logic        is_illegal,
    output logic        writes_rd,
    output logic        rd_is_pc,
    output logic        use_c
);

    logic mul_sig;
    logic unused_fields;

    // Condition, S bit and the Rs/Rm selectors do not affect sequencing;
    // the register bank reads them straight off IR.
    assign unused_fields = ^{ir[31:28], ir[20], ir[RS_HI:RS_LO],
                             ir[RM_HI:RM_LO], ir[OPC_LO]};

    // A multiply-shaped word targeting the PC is rejected rather than being
    // treated as data processing, so the signature test is kept separate.
    always_comb begin
        mul_sig    = (ir[27:22] == 6'b000000) && (ir[7:4] == MUL_SIG);
        is_mul     = mul_sig && (ir[RN_HI:RN_LO] != PC_IDX);
        is_dp      = (ir[27:26] == 2'b00) && !mul_sig;
        is_illegal = !is_mul && !is_dp;
        writes_rd  = is_mul || (is_dp && (ir[OPC_HI:OPC_HI-1] != CMP_OPC_MASK));
        rd_is_pc   = (ir[RD_HI:RD_LO] == PC_IDX);
        use_c      = !ir[IMM_BIT] && ir[SHREG_BIT];
    end

endmodule

// File: rtl/reg_bank_seq_ctrl.sv
// Per-instruction sequencer driving the register bank control lines.
// Accepts one instruction per valid/ready handshake, holds it on IR and
// steps through EXEC, an optional multi-cycle MUL phase and PC_INC.
// Ports:
//   clk, rst         - clock and synchronous active-high reset
//   ir_in, ir_valid  - instruction offered by fetch
//   ir_ready         - high only in IDLE
//   IR               - registered instruction to the register bank
//   LATCH_REG        - register bank write enable
//   PC_MUX, RD_MUX, DATA_MUX - write path selects
//   REG_GATE_A/B/C   - Rn/Rm/Rs bus drivers
//   busy, done, illegal - status
module reg_bank_seq_ctrl
    import reg_bank_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir_in,
    input  logic        ir_valid,
    output logic        ir_ready,
    output logic [31:0] IR,
    output logic        LATCH_REG,
    output logic        PC_MUX,
    output logic        RD_MUX,
    output logic        DATA_MUX,
    output logic        REG_GATE_A,
    output logic        REG_GATE_B,
    output logic        REG_GATE_C,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;

    logic in_is_mul, in_is_dp, in_is_illegal, in_writes_rd, in_rd_is_pc, in_use_c;
    logic cur_is_mul, cur_is_dp, cur_is_illegal, cur_writes_rd, cur_rd_is_pc, cur_use_c;
    logic unused_flags;

    // The offered word is classified so the first phase is chosen at the
    // accept edge; the held word drives the Moore outputs afterwards.
    reg_bank_ir_decode u_in_decode (
        .ir         (ir_in),
        .is_mul     (in_is_mul),
        .is_dp      (in_is_dp),
        .is_illegal (in_is_illegal),
        .writes_rd  (in_writes_rd),
        .rd_is_pc   (in_rd_is_pc),
        .use_c      (in_use_c)
    );

    reg_bank_ir_decode u_cur_decode (
        .ir         (ir_q),
        .is_mul     (cur_is_mul),
        .is_dp      (cur_is_dp),
        .is_illegal (cur_is_illegal),
        .writes_rd  (cur_writes_rd),
        .rd_is_pc   (cur_rd_is_pc),
        .use_c      (cur_use_c)
    );

    assign unused_flags = ^{in_is_dp, in_writes_rd, in_rd_is_pc, in_use_c,
                            cur_is_mul, cur_is_dp};

    // State, instruction and multiply counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ir_q      <= '0;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Next-state logic. An unsupported word skips straight to PC_INC, and a
    // data-processing write to the PC finishes in EXEC since the PC was
    // overwritten and must not be incremented.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ir_valid) begin
                    ir_d      = ir_in;
                    mul_cnt_d = '0;
                    if (in_is_illegal)
                        state_d = ST_PC_INC;
                    else if (in_is_mul)
                        state_d = ST_MUL;
                    else
                        state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cur_writes_rd && cur_rd_is_pc)
                    state_d = ST_IDLE;
                else
                    state_d = ST_PC_INC;
            end
            ST_MUL: begin
                mul_cnt_d = mul_cnt_q + 4'd1;
                if (mul_cnt_q == MUL_LAST)
                    state_d = ST_PC_INC;
            end
            ST_PC_INC: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore output decode. Defaults are the quiet IDLE-like values so the
    // buses float and nothing is written unless a phase asks for it.
    always_comb begin
        ir_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        illegal    = 1'b0;
        LATCH_REG  = 1'b0;
        PC_MUX     = 1'b0;
        RD_MUX     = 1'b1;
        DATA_MUX   = 1'b1;
        REG_GATE_A = 1'b0;
        REG_GATE_B = 1'b0;
        REG_GATE_C = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ir_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_EXEC: begin
                REG_GATE_A = 1'b1;
                REG_GATE_B = !ir_q[IMM_BIT];
                REG_GATE_C = cur_use_c;
                LATCH_REG  = cur_writes_rd;
                done       = cur_writes_rd && cur_rd_is_pc;
            end
            ST_MUL: begin
                REG_GATE_B = 1'b1;
                REG_GATE_C = 1'b1;
                RD_MUX     = 1'b0;
                LATCH_REG  = (mul_cnt_q == MUL_LAST);
            end
            ST_PC_INC: begin
                LATCH_REG = 1'b1;
                PC_MUX    = 1'b1;
                DATA_MUX  = 1'b0;
                done      = 1'b1;
                illegal   = cur_is_illegal;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    assign IR = ir_q;

endmodule
